// File: rtl/board_io_frontend.sv
// Board-side I/O front end: debounced switches, per-digit 7-segment decode,
// timed LCD enable-pulse sequencer and a sticky illegal-register-use flag.
module board_io_frontend #(
  parameter int NUM_SW           = 17,
  parameter int NUM_HEX          = 8,
  parameter int DEB_CYCLES       = 500000,
  parameter int LCD_SETUP_CYCLES = 2,
  parameter int LCD_EN_CYCLES    = 25,
  parameter int LCD_HOLD_CYCLES  = 2,
  parameter int HEX_ACTIVE_LOW   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_SW-1:0]      sw_pad_i,
  output logic [31:0]            io_sw_o,
  input  logic [NUM_HEX*32-1:0]  io_hex_i,
  input  logic [NUM_HEX-1:0]     hex_decode_i,
  output logic [NUM_HEX*7-1:0]   hex_pad_o,
  input  logic [31:0]            io_lcd_i,
  output logic [7:0]             lcd_data_o,
  output logic                   lcd_rw_o,
  output logic                   lcd_rs_o,
  output logic                   lcd_en_o,
  output logic                   lcd_on_o,
  output logic                   lcd_busy_o,
  input  logic                   err_clr_i,
  output logic                   err_o
);
  // state    | meaning
  // ST_IDLE  | data/RS/RW follow the register, waiting for an EN request edge
  // ST_SETUP | latched data driven, EN low
  // ST_PULSE | EN high
  // ST_HOLD  | EN low, latched data still driven
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD} lcd_state_t;

  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam int LCD_MAX_A = (LCD_SETUP_CYCLES > LCD_EN_CYCLES) ? LCD_SETUP_CYCLES : LCD_EN_CYCLES;
  localparam int LCD_MAX = (LCD_MAX_A > LCD_HOLD_CYCLES) ? LCD_MAX_A : LCD_HOLD_CYCLES;
  localparam int LCD_CNT_W = $clog2(LCD_MAX + 1);
  localparam logic HEX_OFF = (HEX_ACTIVE_LOW != 0);

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  logic [NUM_SW-1:0] sw_meta, sw_sync, sw_stable;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_pad_i;
      sw_sync <= sw_meta;
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    logic [DEB_W-1:0] cnt;
    logic             stable_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt      <= '0;
        stable_q <= 1'b0;
      end else if (sw_sync[i] == stable_q) begin
        cnt <= '0;
      end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
        stable_q <= sw_sync[i];
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign sw_stable[i] = stable_q;
  end

  assign io_sw_o = 32'(sw_stable);

  logic [NUM_HEX*7-1:0] hex_next, hex_q;
  logic [NUM_HEX-1:0]   hex_bad;

  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
    logic [31:0] digit;
    logic [6:0]  seg;
    assign digit               = io_hex_i[32*k +: 32];
    assign seg                 = hex_decode_i[k] ? seg7(digit[3:0]) : digit[6:0];
    assign hex_next[7*k +: 7]  = HEX_OFF ? ~seg : seg;
    assign hex_bad[k]          = hex_decode_i[k] ? |digit[31:4] : |digit[31:7];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hex_q <= {(NUM_HEX*7){HEX_OFF}};
    else         hex_q <= hex_next;
  end

  assign hex_pad_o = hex_q;

  lcd_state_t           state_q, state_d;
  logic [LCD_CNT_W-1:0] lcd_cnt;
  logic                 req_prev, req_edge, cnt_zero;
  logic [7:0]           data_q;
  logic                 rw_q, rs_q, on_q, err_q, err_set;

  assign req_edge = io_lcd_i[10] & ~req_prev;
  assign cnt_zero = (lcd_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_edge) state_d = ST_SETUP;
      ST_SETUP: if (cnt_zero) state_d = ST_PULSE;
      ST_PULSE: if (cnt_zero) state_d = ST_HOLD;
      ST_HOLD:  if (cnt_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lcd_en_o   = (state_q == ST_PULSE);
    lcd_busy_o = (state_q != ST_IDLE);
  end

  // One shared down-counter, reloaded with the length of each phase on entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lcd_cnt <= '0;
    end else if (state_q != state_d) begin
      case (state_d)
        ST_SETUP: lcd_cnt <= LCD_CNT_W'(LCD_SETUP_CYCLES - 1);
        ST_PULSE: lcd_cnt <= LCD_CNT_W'(LCD_EN_CYCLES - 1);
        ST_HOLD:  lcd_cnt <= LCD_CNT_W'(LCD_HOLD_CYCLES - 1);
        default:  lcd_cnt <= '0;
      endcase
    end else if (!cnt_zero) begin
      lcd_cnt <= lcd_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      rw_q     <= 1'b0;
      rs_q     <= 1'b0;
      on_q     <= 1'b0;
      req_prev <= 1'b0;
    end else begin
      req_prev <= io_lcd_i[10];
      on_q     <= io_lcd_i[31];
      if (state_q == ST_IDLE) begin
        data_q <= io_lcd_i[7:0];
        rw_q   <= io_lcd_i[8];
        rs_q   <= io_lcd_i[9];
      end
    end
  end

  assign lcd_data_o = data_q;
  assign lcd_rw_o   = rw_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_on_o   = on_q;

  assign err_set = (|hex_bad) | (|io_lcd_i[30:11]) | (req_edge & (state_q != ST_IDLE));

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_set | (err_q & ~err_clr_i);
  end

  assign err_o = err_q;

endmodule

// File: doc/board_io_frontend.md
Name: board_io_frontend

Overview:
Parametrised board-side I/O front end sitting between the core's memory-mapped I/O registers and the FPGA pads. It adds three things to the plain pin mapping:
- Switch synchronisation and debouncing.
- Per-digit selectable 7-segment decode.
- A timed LCD enable-pulse sequencer.
It also raises a sticky error flag for illegal register contents. It replaces the pure combinational pad assignments in the top-level board wrapper.

Parameters:
NUM_SW, 17, number of switch inputs debounced (1..32)
NUM_HEX, 8, number of 7-segment digits (1..8)
DEB_CYCLES, 500000, stable cycles required before a switch change is accepted (10 ms at 50 MHz; >=2)
LCD_SETUP_CYCLES, 2, cycles data/RS/RW are held before EN rises (>=1)
LCD_EN_CYCLES, 25, EN high width in cycles (500 ns at 50 MHz; >=1)
LCD_HOLD_CYCLES, 2, cycles data held after EN falls (>=1)
HEX_ACTIVE_LOW, 1, 1 = segment pads active-low

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
sw_pad_i  in  NUM_SW  raw switch pads
io_sw_o  out  32  debounced switches, zero-extended
io_hex_i  in  NUM_HEX*32  hex registers, digit k at [32k+31:32k]
hex_decode_i  in  NUM_HEX  per digit: 1 = decode nibble [3:0], 0 = raw segments [6:0]
hex_pad_o  out  NUM_HEX*7  segment pads, digit k at [7k+6:7k], bit0=a .. bit6=g
io_lcd_i  in  32  LCD register: [7:0] data, [8] RW, [9] RS, [10] EN request, [31] ON
lcd_data_o  out  8  LCD data pads
lcd_rw_o  out  1  LCD RW
lcd_rs_o  out  1  LCD RS
lcd_en_o  out  1  LCD EN, timed
lcd_on_o  out  1  LCD power/backlight
lcd_busy_o  out  1  high while sequencer not IDLE
err_clr_i  in  1  clears err_o
err_o  out  1  sticky illegal-use flag

Behaviour:
Reset: one clock; reset is asynchronous and active-low on rst_ni. All state clears immediately on assertion, mid-sequence included. On reset:
- io_sw_o=0.
- hex_pad_o all segments off: all 1s if HEX_ACTIVE_LOW, else 0.
- lcd_data_o/rw/rs/en/on=0, lcd_busy_o=0, err_o=0, FSM=IDLE.

Switches:
- Each bit passes a 2-flop synchroniser, then its own debounce counter.
- Synced bit == stable bit: counter clears.
- Synced bit differs: counter increments. When the count reaches DEB_CYCLES-1, the stable bit takes the new value and the counter clears.
- Any glitch shorter than DEB_CYCLES resets that bit's counter; no change is accepted.
- Pad-to-io_sw_o latency is exactly 2 + DEB_CYCLES cycles.
- io_sw_o[31:NUM_SW]=0.

Hex:
- Registered, 1-cycle latency.
- Decode mode: nibble 0..F maps to standard a..g patterns, e.g. 0 -> 0x3F, 1 -> 0x06, 8 -> 0x7F, A -> 0x77, F -> 0x71.
- Raw mode: passes [6:0].
- Output is inverted when HEX_ACTIVE_LOW=1.

LCD FSM (IDLE, SETUP, PULSE, HOLD):
- EN request edge = rising edge of io_lcd_i[10] against its previous-cycle sample.
- IDLE: lcd_data/rs/rw track io_lcd_i each cycle, lcd_en_o=0. On an edge, latch data/RS/RW and go to SETUP.
- SETUP: lasts LCD_SETUP_CYCLES, EN=0, then PULSE.
- PULSE: lasts LCD_EN_CYCLES, EN=1, then HOLD.
- HOLD: lasts LCD_HOLD_CYCLES, EN=0, then IDLE.
- A single shared down-counter times all three phases.
- lcd_busy_o=1 in SETUP/PULSE/HOLD.
- Latched data/RS/RW are held constant from SETUP through HOLD.
- A new edge while busy is dropped (no queueing) and sets err_o.
- A level held high does not retrigger; the request must fall and rise again.
- lcd_on_o = io_lcd_i[31], registered, independent of the FSM.

Error flag:
- err_o is set on any cycle where:
  - any digit has nonzero unused bits: [31:7] in raw mode or [31:4] in decode mode, or
  - io_lcd_i[30:11] != 0, or
  - an EN edge is dropped while busy.
- err_clr_i clears err_o. If set and clear occur in the same cycle, set wins.

Test Plan:
1. Reset then release, DEB_CYCLES=4: drive sw_pad_i[0]=1 steadily -> io_sw_o=0x1 exactly 6 cycles after the pad change. Pulse sw_pad_i[3] high for 3 cycles -> io_sw_o unchanged.
2. hex_decode_i[0]=1, io_hex digit0=0x0000000A -> hex_pad_o[6:0]=~0x77=0x08 one cycle later. Switch to raw with 0x00000006 -> 0x79.
3. LCD with defaults: io_lcd_i=0x0000_0641 (EN=1, RS=1, data=0x41) from IDLE -> busy for 2+25+2=29 cycles; EN high on cycles 3..27 after the edge; data=0x41 and RS=1 throughout; back to IDLE, err_o=0.
4. Second EN edge 10 cycles into a transaction -> ignored, the original pulse completes unchanged, err_o=1. Then err_clr_i for 1 cycle -> err_o=0.
5. io_hex digit2 raw = 0x00000180 -> err_o=1 next cycle. Same-cycle err_clr_i with the condition still present -> err_o stays 1.
6. Assert rst_ni=0 mid-PULSE -> lcd_en_o=0, busy=0, hex pads blank immediately, without waiting for a clock edge.
